// File: rtl/tree_accumulator.sv
// Accumulates Chunks adder-tree partial sums into a dot product, then rounds, shifts and
// saturates it to int8 behind a 2-entry output buffer with upstream slot reservation.
module tree_accumulator #(
   parameter int unsigned TreeLatency = 2,
   parameter int unsigned Chunks      = 4,
   parameter int unsigned AccWidth    = 20,
   parameter int unsigned Shift       = 4
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              tree_valid_in,
   output logic              ready_out,
   input  logic signed [7:0] tree_sum_in,
   output logic signed [7:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow_out
);

   localparam int unsigned CntW = (Chunks > 1) ? $clog2(Chunks) : 1;
   localparam int unsigned InfW = $clog2(TreeLatency + 3);
   localparam logic [CntW-1:0] LastCnt = CntW'(Chunks - 1);
   localparam logic signed [AccWidth:0] RndAdd = (AccWidth + 1)'((2 ** Shift) / 2);
   localparam logic signed [AccWidth:0] SatMax = (AccWidth + 1)'(127);
   localparam logic signed [AccWidth:0] SatMin = (AccWidth + 1)'(-128);

   logic [CntW-1:0]            in_cnt_q, in_cnt_d;
   logic [TreeLatency-1:0]     dl_v_q, dl_f_q, dl_l_q;
   logic [TreeLatency-1:0]     dl_v_d, dl_f_d, dl_l_d;
   logic signed [AccWidth-1:0] acc_q, acc_d, acc_sum, sum_ext;
   logic signed [AccWidth:0]   rsum, rshift;
   logic [7:0]                 mem_q [2];
   logic                       wr_q, rd_q, ovf_q;
   logic [1:0]                 count_q;
   logic [InfW-1:0]            inflight;
   logic                       accept, tok_v, tok_f, tok_l, push, pop, sat;
   logic [7:0]                 res;

   // A vector's FIFO slot is claimed at its first beat, so ready never drops mid-vector.
   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < TreeLatency; i++) begin
         inflight = inflight + InfW'(dl_v_q[i] && dl_l_q[i]);
      end
      ready_out = (in_cnt_q != '0) || ((InfW'(count_q) + inflight) < InfW'(2));
   end

   always_comb begin
      accept = tree_valid_in && ready_out;
      tok_v  = dl_v_q[TreeLatency-1];
      tok_f  = dl_f_q[TreeLatency-1];
      tok_l  = dl_l_q[TreeLatency-1];

      in_cnt_d = in_cnt_q;
      if (accept) begin
         in_cnt_d = (in_cnt_q == LastCnt) ? '0 : in_cnt_q + 1'b1;
      end

      dl_v_d = dl_v_q;
      dl_f_d = dl_f_q;
      dl_l_d = dl_l_q;
      dl_v_d[0] = accept;
      dl_f_d[0] = accept && (in_cnt_q == '0);
      dl_l_d[0] = accept && (in_cnt_q == LastCnt);
      for (int unsigned i = 1; i < TreeLatency; i++) begin
         dl_v_d[i] = dl_v_q[i-1];
         dl_f_d[i] = dl_f_q[i-1];
         dl_l_d[i] = dl_l_q[i-1];
      end

      sum_ext = {{(AccWidth - 8){tree_sum_in[7]}}, tree_sum_in};
      acc_sum = (tok_f ? '0 : acc_q) + sum_ext;
      acc_d   = tok_v ? acc_sum : acc_q;

      rsum   = {acc_sum[AccWidth-1], acc_sum} + RndAdd;
      rshift = rsum >>> Shift;
      sat    = 1'b0;
      res    = rshift[7:0];
      if (rshift > SatMax) begin
         res = 8'h7f;
         sat = 1'b1;
      end else if (rshift < SatMin) begin
         res = 8'h80;
         sat = 1'b1;
      end

      push = tok_v && tok_l;
      pop  = (count_q != '0) && out_ready;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         in_cnt_q <= '0;
         dl_v_q   <= '0;
         dl_f_q   <= '0;
         dl_l_q   <= '0;
         acc_q    <= '0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         in_cnt_q <= in_cnt_d;
         dl_v_q   <= dl_v_d;
         dl_f_q   <= dl_f_d;
         dl_l_q   <= dl_l_d;
         acc_q    <= acc_d;
         ovf_q    <= push && sat;
         if (push) begin
            mem_q[wr_q] <= res;
            wr_q        <= ~wr_q;
         end
         if (pop) begin
            rd_q <= ~rd_q;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign out_valid    = (count_q != '0);
   assign out_data     = out_valid ? mem_q[rd_q] : '0;
   assign overflow_out = ovf_q;

   a_no_protocol_violation: assert property (@(posedge clk_in) disable iff (!rst_n_in)
      !(tree_valid_in && !ready_out))
      else $error("tree_valid_in asserted while ready_out low");

   a_no_full_push: assert property (@(posedge clk_in) disable iff (!rst_n_in)
      !(push && (count_q == 2'd2) && !pop))
      else $error("push into full output buffer");

endmodule

// File: tb/tb_tree_accumulator.sv
// Bench for tree_accumulator: two instances (Shift 4 and Shift 0) share one stimulus stream
// and are checked against a queue-based arithmetic model plus directed vector tables.
module tb_tree_accumulator;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              beat_valid = 1'b0;
   logic signed [7:0] beat_sum = '0;
   logic signed [7:0] tp [2];
   logic signed [7:0] tree_sum;
   logic              out_ready = 1'b0;
   logic              ready_a, ready_b, val_a, val_b, ovf_a, ovf_b;
   logic signed [7:0] data_a, data_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stalls = 0;
   int pops = 0;
   int last_pop_a = 0;
   int last_beat_cyc = 0;
   int cur[$];
   int exp_a[$];
   int exp_b[$];
   int pop_cyc[$];
   int mdl_ovf_a = 0, mdl_ovf_b = 0, seen_ovf_a = 0, seen_ovf_b = 0;

   typedef struct {
      int s[4];
      int ea;
      int eb;
      int ob;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural stand-in for the fixed-latency adder tree (2 stages).
   always @(posedge clk) begin
      tp[0] <= beat_sum;
      tp[1] <= tp[0];
   end
   assign tree_sum = tp[1];

   tree_accumulator #(.TreeLatency(2), .Chunks(4), .AccWidth(20), .Shift(4)) u_dut (
      .clk_in(clk), .rst_n_in(rst_n), .tree_valid_in(beat_valid), .ready_out(ready_a),
      .tree_sum_in(tree_sum), .out_data(data_a), .out_valid(val_a), .out_ready(out_ready),
      .overflow_out(ovf_a));

   tree_accumulator #(.TreeLatency(2), .Chunks(4), .AccWidth(20), .Shift(0)) u_sat (
      .clk_in(clk), .rst_n_in(rst_n), .tree_valid_in(beat_valid), .ready_out(ready_b),
      .tree_sum_in(tree_sum), .out_data(data_b), .out_valid(val_b), .out_ready(out_ready),
      .overflow_out(ovf_b));

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int round_sat(input int total, input int sh, output int ovf);
      int d, n, q;
      d = 1 << sh;
      n = total + d / 2;
      q = n / d;
      if (n < 0 && (n % d) != 0) q = q - 1;
      ovf = 0;
      if (q > 127) begin q = 127; ovf = 1; end
      else if (q < -128) begin q = -128; ovf = 1; end
      return q;
   endfunction

   // Scoreboard: sees each accepted beat and each pop just before the edge that acts on it.
   always @(negedge clk) begin
      int total, oa, ob;
      if (!rst_n) begin
         cur.delete();
         exp_a.delete();
         exp_b.delete();
      end else begin
         if (beat_valid && ready_a) begin
            chk("ready_match", int'(ready_b), int'(ready_a));
            cur.push_back(int'(beat_sum));
            if (cur.size() == 4) begin
               total = cur[0] + cur[1] + cur[2] + cur[3];
               exp_a.push_back(round_sat(total, 4, oa));
               exp_b.push_back(round_sat(total, 0, ob));
               mdl_ovf_a += oa;
               mdl_ovf_b += ob;
               cur.delete();
            end
         end
         if (val_a && out_ready) begin
            chk("out_expected", int'(exp_a.size() > 0), 1);
            if (exp_a.size() > 0) begin
               last_pop_a = int'(data_a);
               chk("data_shift4", int'(data_a), exp_a.pop_front());
               chk("data_shift0", int'(data_b), exp_b.pop_front());
            end
            pops++;
            pop_cyc.push_back(cyc);
         end
         if (ovf_a) seen_ovf_a++;
         if (ovf_b) seen_ovf_b++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int v);
      int n;
      n = 0;
      beat_valid = 1'b0;
      while (!ready_a && n < 100) begin
         tick();
         n++;
         stalls++;
      end
      if (!ready_a) begin
         chk("beat_ready_timeout", int'(ready_a), 1);
      end else begin
         beat_valid = 1'b1;
         beat_sum = 8'(v);
         last_beat_cyc = cyc;
         tick();
         beat_valid = 1'b0;
         beat_sum = 8'($urandom);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_a.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      chk(name, exp_a.size(), 0);
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_valid"}, int'(val_a) + int'(val_b), 0);
      chk({name, "_data"}, int'(data_a) + int'(data_b), 0);
      chk({name, "_ovf"}, int'(ovf_a) + int'(ovf_b), 0);
   endtask

   initial begin
      int t0, n, p0, lowcnt;

      tbl[0] = '{s: '{16, 16, 16, 16},     ea: 4,   eb: 64,   ob: 0};
      tbl[1] = '{s: '{-6, -6, -6, -6},     ea: -1,  eb: -24,  ob: 0};
      tbl[2] = '{s: '{-7, -6, -6, -6},     ea: -2,  eb: -25,  ob: 0};
      tbl[3] = '{s: '{127, 127, 127, 127}, ea: 32,  eb: 127,  ob: 1};
      tbl[4] = '{s: '{-128, -128, -128, -128}, ea: -32, eb: -128, ob: 1};
      tbl[5] = '{s: '{30, 30, 30, 30},     ea: 8,   eb: 120,  ob: 0};

      // Reset state
      repeat (3) begin
         tick();
         chk_idle("in_reset");
      end
      rst_n = 1'b1;
      #1;
      chk_idle("after_reset");
      chk("after_reset_ready", int'(ready_a) + int'(ready_b), 2);
      tick();

      // Directed vectors, one at a time, consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         for (int b = 0; b < 4; b++) begin
            beat(tbl[i].s[b]);
            if (b == 0) t0 = last_beat_cyc;
         end
         n = 0;
         while (!val_a && n < 20) begin
            tick();
            n++;
         end
         chk($sformatf("vec%0d_valid", i), int'(val_a), 1);
         if (i == 0) chk("latency_first_to_valid", cyc - t0, 6);
         chk($sformatf("vec%0d_data_s4", i), int'(data_a), tbl[i].ea);
         chk($sformatf("vec%0d_data_s0", i), int'(data_b), tbl[i].eb);
         chk($sformatf("vec%0d_ovf_s0", i), int'(ovf_b), tbl[i].ob);
         chk($sformatf("vec%0d_ovf_s4", i), int'(ovf_a), 0);
         tick();
         chk($sformatf("vec%0d_ovf_one_cycle", i), int'(ovf_b), 0);
      end

      // Backpressure: three vectors with the consumer stalled
      out_ready = 1'b0;
      for (int b = 0; b < 4; b++) beat(16);
      for (int b = 0; b < 4; b++) beat(-6);
      chk("bp_ready_drop", int'(ready_a), 0);
      lowcnt = 0;
      repeat (5) begin
         tick();
         if (!ready_a) lowcnt++;
      end
      chk("bp_ready_stays_low", lowcnt, 5);
      chk("bp_two_buffered", int'(val_a), 1);
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) beat(30);
      drain("bp_drain");

      // Simultaneous push/pop: continuous vectors, consumer ready
      stalls = 0;
      pop_cyc.delete();
      for (int v = 0; v < 4; v++) begin
         for (int b = 0; b < 4; b++) beat($urandom_range(0, 255) - 128);
      end
      drain("pp_drain");
      chk("pp_no_stalls", stalls, 0);
      chk("pp_result_count", pop_cyc.size(), 4);
      for (int k = 1; k < pop_cyc.size(); k++) begin
         chk($sformatf("pp_interval%0d", k), pop_cyc[k] - pop_cyc[k-1], 4);
      end

      // Reset in the middle of a vector
      beat(16);
      beat(16);
      rst_n = 1'b0;
      #1;
      chk_idle("mid_reset");
      repeat (3) begin
         tick();
         chk_idle("mid_reset_hold");
      end
      rst_n = 1'b1;
      #1;
      chk("mid_reset_ready", int'(ready_a), 1);
      p0 = pops;
      for (int b = 0; b < 4; b++) beat(16);
      repeat (15) tick();
      chk("mid_reset_one_output", pops - p0, 1);
      chk("mid_reset_value", last_pop_a, 4);

      // Randomized traffic against the scoreboard
      for (int c = 0; c < 500; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (ready_a && $urandom_range(0, 4) != 0) begin
            beat_valid = 1'b1;
            beat_sum = 8'($urandom);
         end else begin
            beat_valid = 1'b0;
            beat_sum = 8'($urandom);
         end
         tick();
      end
      beat_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (cur.size() != 0 && n < 4) begin
         beat($urandom_range(0, 255) - 128);
         n++;
      end
      drain("rand_drain");
      repeat (4) tick();
      chk("ovf_pulses_s4", seen_ovf_a, mdl_ovf_a);
      chk("ovf_pulses_s0", seen_ovf_b, mdl_ovf_b);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
